// File: rtl/decode_ctrl_pkg.sv
// Shared decode-stage types, FSM states and RV64 major opcode constants.
package pipes;

  typedef logic [31:0] u32;
  typedef logic [63:0] u64;

  typedef enum logic [2:0] {I, S, B, U, J, NONE} decode_op_t;

  typedef enum logic [1:0] {EMPTY, FULL, HAZARD} dec_state_t;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  localparam u32 NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/decode_ctrl_immsel_dec.sv
// Opcode decode: immediate format select and source-register usage.
module immsel_dec
  import pipes::*;
(
  input  logic [6:0] opcode_i,
  output decode_op_t immsel_o,
  output logic       rs1_used_o,
  output logic       rs2_used_o
);

  always_comb begin
    immsel_o   = NONE;
    rs1_used_o = 1'b1;
    rs2_used_o = 1'b0;
    case (opcode_i)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_OP_IMM32: immsel_o = I;
      OPC_STORE: begin
        immsel_o   = S;
        rs2_used_o = 1'b1;
      end
      OPC_BRANCH: begin
        immsel_o   = B;
        rs2_used_o = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        immsel_o   = U;
        rs1_used_o = 1'b0;
      end
      OPC_JAL: begin
        immsel_o   = J;
        rs1_used_o = 1'b0;
      end
      OPC_OP, OPC_OP32: rs2_used_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode stage holding register with load-use hazard bubble and flush handling.
module decode_ctrl
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        f_valid,
  input  u32          f_instr,
  input  u64          f_pc,
  output logic        f_ready,
  input  logic        e_ready,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  output logic        d_valid,
  output u32          d_instr,
  output u64          d_pc,
  output decode_op_t  d_immsel,
  output logic [4:0]  d_rs1,
  output logic [4:0]  d_rs2,
  output logic [4:0]  d_rd,
  output logic [31:0] hazard_cnt
);

  dec_state_t  state_q, state_d;
  u32          instr_q;
  u64          pc_q;
  logic [31:0] cnt_q, cnt_d;
  logic        load;
  logic        rs1_used, rs2_used;
  logic        hz;

  immsel_dec u_immsel_dec (
    .opcode_i   (instr_q[6:0]),
    .immsel_o   (d_immsel),
    .rs1_used_o (rs1_used),
    .rs2_used_o (rs2_used)
  );

  assign d_instr    = instr_q;
  assign d_pc       = pc_q;
  assign d_rs1      = instr_q[19:15];
  assign d_rs2      = instr_q[24:20];
  assign d_rd       = instr_q[11:7];
  assign hazard_cnt = cnt_q;

  assign hz = ex_memread && (ex_rd != '0) &&
              ((rs1_used && (ex_rd == d_rs1)) || (rs2_used && (ex_rd == d_rs2)));

  // Reset and flush both override the per-state behaviour; reset wins in the register block.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    d_valid = 1'b0;
    f_ready = 1'b0;
    if (reset || flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          f_ready = 1'b1;
          if (f_valid) begin
            load    = 1'b1;
            state_d = FULL;
          end
        end
        FULL: begin
          if (hz) begin
            state_d = HAZARD;
            if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
          end else begin
            d_valid = 1'b1;
            if (e_ready) begin
              f_ready = 1'b1;
              if (f_valid) load = 1'b1;
              else         state_d = EMPTY;
            end
          end
        end
        HAZARD:  state_d = FULL;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        instr_q <= f_instr;
        pc_q    <= f_pc;
      end
    end
  end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 SHALL use the shared types u32, u64 and decode_op_t.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port clk: input, 1 bit, rising-edge clock.
REQ-004 Port reset: input, 1 bit, synchronous active-high reset.
REQ-005 Port f_valid: input, 1 bit, fetch presents an instruction.
REQ-006 Port f_instr: input, u32, raw fetched instruction.
REQ-007 Port f_pc: input, u64, PC of f_instr.
REQ-008 Port f_ready: output, 1 bit, decode accepts the fetch beat this cycle.
REQ-009 Port e_ready: input, 1 bit, execute accepts the decode beat this cycle.
REQ-010 Port ex_memread: input, 1 bit, the instruction in execute is a load.
REQ-011 Port ex_rd: input, 5 bits, destination register of the instruction in execute.
REQ-012 Port flush: input, 1 bit, branch/jump redirect that kills decode.
REQ-013 Port d_valid: output, 1 bit, the decode beat is valid.
REQ-014 Ports d_instr (u32) and d_pc (u64): outputs, the held instruction and its PC.
REQ-015 Port d_immsel: output, decode_op_t, immediate-format select for the immediate generator.
REQ-016 Ports d_rs1, d_rs2, d_rd: outputs, 5 bits each, fields [19:15], [24:20] and [11:7] of d_instr.
REQ-017 Port hazard_cnt: output, 32 bits, count of load-use bubbles inserted.

Function
REQ-018 SHALL implement FSM states EMPTY, FULL and HAZARD over one instruction register (instr, pc).
REQ-019 In EMPTY: f_ready=1 and d_valid=0; on f_valid && !flush the register loads f_instr/f_pc and the next state is FULL.
REQ-020 hz (combinational) = ex_memread && ex_rd!=0 && ((rs1 used && ex_rd==d_rs1) || (rs2 used && ex_rd==d_rs2)).
REQ-021 rs1 is used for every opcode except LUI, AUIPC and JAL; rs2 is used only for opcodes 0110011, 0111011, 0100011 and 1100011.
REQ-022 In FULL with hz: d_valid=0 and f_ready=0; the next state is HAZARD; hazard_cnt increments, saturating at 32'hFFFF_FFFF.
REQ-023 In FULL with !hz and e_ready: d_valid=1 and f_ready=1; with f_valid the register reloads and the state stays FULL, otherwise the next state is EMPTY.
REQ-024 In FULL with !hz and !e_ready: d_valid=1, f_ready=0, and the register and state hold.
REQ-025 HAZARD SHALL last exactly one cycle: d_valid=0, f_ready=0, ex_* ignored, next state FULL.
REQ-026 flush SHALL have the highest priority in every state: d_valid=0, f_ready=0 that cycle, next state EMPTY, and the fetch beat is dropped.
REQ-027 d_immsel decode from opcode [6:0]:
- I for 0010011, 0000011, 1100111, 0011011
- S for 0100011
- B for 1100011
- U for 0110111, 0010111
- J for 1101111
- NONE otherwise
REQ-028 The register SHALL change only on a load; instruction and PC are transferred with zero added latency beyond the one-cycle register.

Reset
REQ-029 Reset SHALL force state=EMPTY, instr=32'h0000_0013 (NOP), pc=0 and hazard_cnt=0.
REQ-030 While reset is asserted: d_valid=0 and f_ready=0.
REQ-031 Reset asserted mid-operation (FULL or HAZARD) SHALL discard the held instruction and take priority over flush.

Structure
REQ-032 decode_op_t (I, S, B, U, J, NONE) and the opcode constants SHALL reside in package pipes.
REQ-033 The opcode-to-immsel and rs-used decode SHALL be a combinational sub-module named immsel_dec.

Verification
REQ-034 Load 0x00A00093 (addi x1,x0,10) with e_ready=1 -> d_valid=1 the next cycle, d_immsel=I, d_rd=1, then EMPTY.
REQ-035 Hold 0x002081B3 (add x3,x1,x2) with ex_memread=1 and ex_rd=2 -> exactly one d_valid=0 bubble, hazard_cnt=1, then d_valid=1 with the same instruction.
REQ-036 Same add with ex_rd=0, or with ex_memread=0 -> no bubble and hazard_cnt unchanged.
REQ-037 FULL with e_ready=0 for 3 cycles -> d_instr and d_pc stable, f_ready=0; on e_ready=1, back-to-back reload with f_valid=1.
REQ-038 flush asserted together with f_valid while in FULL -> d_valid=0 that cycle, EMPTY next cycle, and the fetch beat is not loaded.
REQ-039 reset asserted in HAZARD -> EMPTY, hazard_cnt=0 and instr=0x00000013 on the next cycle.
